calc_stack_ctrl: RTL

Operand-stack controller for the calculator datapath. It owns one simple-dual-port block RAM instance (port a: write/read, port b: read, both registered on the falling clock edge) and turns push/pop/clear commands into RAM port activity. It keeps the stack pointer and returns the top one or two operands to the ALU sequencer. Overflow and underflow are detected and reported as sticky flags.

---
 rtl/calc_stack_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_stack_ctrl.sv
// Operand-stack controller: maps push/pop/clear commands onto an external
// simple-dual-port RAM, tracks depth and reports sticky overflow/underflow.
module calc_stack_ctrl #(
    parameter int DWIDTH  = 32,
    parameter int LEN     = 64,
    parameter int LOG_LEN = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [DWIDTH-1:0]   push_data,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DWIDTH-1:0]   rsp_a,
    output logic [DWIDTH-1:0]   rsp_b,
    output logic [LOG_LEN:0]    depth,
    output logic                full,
    output logic                empty,
    output logic                ovf_flag,
    output logic                unf_flag,
    output logic                ram_ena,
    output logic                ram_wea,
    output logic                ram_enb,
    output logic [LOG_LEN-1:0]  ram_addra,
    output logic [LOG_LEN-1:0]  ram_addrb,
    output logic [DWIDTH-1:0]   ram_dla,
    input  logic [DWIDTH-1:0]   ram_doa,
    input  logic [DWIDTH-1:0]   ram_dob
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP
    } state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_POP2  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [LOG_LEN:0]   DEPTH_ONE = (LOG_LEN+1)'(1);
    localparam logic [LOG_LEN:0]   DEPTH_TWO = (LOG_LEN+1)'(2);
    localparam logic [LOG_LEN:0]   DEPTH_MAX = (LOG_LEN+1)'(LEN);
    localparam logic [LOG_LEN-1:0] ADDR_ONE  = LOG_LEN'(1);
    localparam logic [LOG_LEN-1:0] ADDR_TWO  = LOG_LEN'(2);

    state_t              r_state;
    logic                r_wr_hold;
    logic                r_pop2;
    logic [LOG_LEN:0]    r_depth;
    logic                r_ovf;
    logic                r_unf;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DWIDTH-1:0]   r_rsp_a;
    logic [DWIDTH-1:0]   r_rsp_b;
    logic                r_ram_ena;
    logic                r_ram_wea;
    logic                r_ram_enb;
    logic [LOG_LEN-1:0]  r_ram_addra;
    logic [LOG_LEN-1:0]  r_ram_addrb;
    logic [DWIDTH-1:0]   r_ram_dla;

    logic                w_full;
    logic                w_empty;
    logic [LOG_LEN-1:0]  w_addr_top;
    logic [LOG_LEN-1:0]  w_addr_second;

    assign w_full        = (r_depth == DEPTH_MAX);
    assign w_empty       = (r_depth == '0);
    // Address wraps harmlessly when depth==LEN: the low bits are 0, minus 1 gives LEN-1.
    assign w_addr_top    = r_depth[LOG_LEN-1:0] - ADDR_ONE;
    assign w_addr_second = r_depth[LOG_LEN-1:0] - ADDR_TWO;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_hold   <= 1'b0;
            r_pop2      <= 1'b0;
            r_depth     <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
            r_ram_ena   <= 1'b0;
            r_ram_wea   <= 1'b0;
            r_ram_enb   <= 1'b0;
            r_ram_addra <= '0;
            r_ram_addrb <= '0;
            r_ram_dla   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_ram_ena   <= 1'b0;
            r_ram_wea   <= 1'b0;
            r_ram_enb   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!w_full) begin
                                    r_state     <= S_WR;
                                    r_wr_hold   <= 1'b0;
                                    r_ram_ena   <= 1'b1;
                                    r_ram_wea   <= 1'b1;
                                    r_ram_addra <= r_depth[LOG_LEN-1:0];
                                    r_ram_dla   <= push_data;
                                end else begin
                                    r_ovf       <= 1'b1;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                end
                            end
                            OP_POP: begin
                                if (!w_empty) begin
                                    r_state     <= S_RD;
                                    r_pop2      <= 1'b0;
                                    r_ram_enb   <= 1'b1;
                                    r_ram_addrb <= w_addr_top;
                                end else begin
                                    r_unf       <= 1'b1;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                end
                            end
                            OP_POP2: begin
                                if (r_depth >= DEPTH_TWO) begin
                                    r_state     <= S_RD;
                                    r_pop2      <= 1'b1;
                                    r_ram_enb   <= 1'b1;
                                    r_ram_addrb <= w_addr_top;
                                    r_ram_ena   <= 1'b1;
                                    r_ram_addra <= w_addr_second;
                                end else begin
                                    r_unf       <= 1'b1;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_err   <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                r_depth <= '0;
                                r_ovf   <= 1'b0;
                                r_unf   <= 1'b0;
                            end
                        endcase
                    end
                end

                // Write happens in the first WR cycle; the second lets depth
                // commit only after the RAM has sampled the word.
                S_WR: begin
                    if (!r_wr_hold) begin
                        r_wr_hold <= 1'b1;
                    end else begin
                        r_wr_hold <= 1'b0;
                        r_depth   <= r_depth + DEPTH_ONE;
                        r_state   <= S_IDLE;
                    end
                end

                S_RD: begin
                    r_state     <= S_CAP;
                    r_rsp_a     <= ram_dob;
                    r_rsp_b     <= r_pop2 ? ram_doa : '0;
                    r_rsp_valid <= 1'b1;
                end

                S_CAP: begin
                    r_depth <= r_depth - (r_pop2 ? DEPTH_TWO : DEPTH_ONE);
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_a     = r_rsp_a;
    assign rsp_b     = r_rsp_b;
    assign depth     = r_depth;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf_flag  = r_ovf;
    assign unf_flag  = r_unf;
    assign ram_ena   = r_ram_ena;
    assign ram_wea   = r_ram_wea;
    assign ram_enb   = r_ram_enb;
    assign ram_addra = r_ram_addra;
    assign ram_addrb = r_ram_addrb;
    assign ram_dla   = r_ram_dla;

endmodule
